// File: rtl/lc3_mem_unit.sv
// LC-3 MAR/MDR memory unit: variable-latency word array behind a wait-state FSM.
// Optional memory-mapped keyboard/display registers when LC3_MEM_MMIO_EN is defined.
//
// Ports:
//   clk, reset (async active-low)
//   Bus                        datapath bus feeding MAR/MDR
//   ldMAR, ldMDR, selMDR       register load controls (selMDR 00=Bus, 01=memOut, else hold)
//   memRd, memWE               access requests, sampled in IDLE only
//   busy, ready, req_err       handshake: in flight / one-cycle done / dropped request
//   MAROut, MDROut, memOut     register contents
//   kb_data, kb_strobe,
//   disp_data, disp_valid      MMIO device ports (LC3_MEM_MMIO_EN only)
module lc3_mem_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Bus,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic [1:0]        selMDR,
  input  logic              memRd,
  input  logic              memWE,
`ifdef LC3_MEM_MMIO_EN
  input  logic [7:0]        kb_data,
  input  logic              kb_strobe,
  output logic [7:0]        disp_data,
  output logic              disp_valid,
`endif
  output logic              busy,
  output logic              ready,
  output logic              req_err,
  output logic [ADDR_W-1:0] MAROut,
  output logic [DATA_W-1:0] MDROut,
  output logic [DATA_W-1:0] memOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  req_err_q, req_err_d;
  logic [ADDR_W-1:0]     mar_q;
  logic [DATA_W-1:0]     mdr_q;
  logic [DATA_W-1:0]     mem_out_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  op_we_q;
  logic                  start;
  logic                  commit;
  logic                  arr_we;
  logic [DATA_W-1:0]     rd_data;

  logic [DATA_W-1:0] mem_q [0:(2**DEPTH_LOG2)-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (memRd || memWE) begin
          start   = 1'b1;
          state_d = S_WAIT;
          cnt_d   = WS;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Conflicting request in IDLE is still taken (as a write) but flagged;
  // any request while busy is simply dropped.
  always_comb begin
    if (state_q == S_IDLE) req_err_d = memRd && memWE;
    else                   req_err_d = memRd || memWE;
  end

`ifdef LC3_MEM_MMIO_EN
  logic [ADDR_W-1:0] maddr_q;
  logic              kb_rdy_q;
  logic [7:0]        kbdr_q;
  logic [7:0]        disp_data_q;
  logic              disp_valid_q;
  logic              is_kbsr, is_kbdr, is_dsr, is_ddr, mmio_hit;
  logic [DATA_W-1:0] mmio_rd;

  assign is_kbsr  = maddr_q == ADDR_W'(16'hFE00);
  assign is_kbdr  = maddr_q == ADDR_W'(16'hFE02);
  assign is_dsr   = maddr_q == ADDR_W'(16'hFE04);
  assign is_ddr   = maddr_q == ADDR_W'(16'hFE06);
  assign mmio_hit = is_kbsr || is_kbdr || is_dsr || is_ddr;

  always_comb begin
    mmio_rd = '0;
    if (is_kbsr) mmio_rd[DATA_W-1] = kb_rdy_q;
    if (is_kbdr) mmio_rd[7:0] = kbdr_q;
    if (is_dsr)  mmio_rd[DATA_W-1] = 1'b1;
  end

  assign rd_data = mmio_hit ? mmio_rd : mem_q[addr_q];
  assign arr_we  = commit && op_we_q && !mmio_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      maddr_q      <= '0;
      kb_rdy_q     <= 1'b0;
      kbdr_q       <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      if (start) maddr_q <= mar_q;
      // A new keystroke takes priority over a KBDR read clearing the flag.
      if (kb_strobe) begin
        kbdr_q   <= kb_data;
        kb_rdy_q <= 1'b1;
      end else if (commit && !op_we_q && is_kbdr) begin
        kb_rdy_q <= 1'b0;
      end
      disp_valid_q <= commit && op_we_q && is_ddr;
      if (commit && op_we_q && is_ddr) disp_data_q <= wdata_q[7:0];
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
`else
  assign rd_data = mem_q[addr_q];
  assign arr_we  = commit && op_we_q;
`endif

  // Array has no reset; commit only ever happens out of WAIT, which
  // reset forces back to IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (arr_we) mem_q[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_err_q <= 1'b0;
      mar_q     <= '0;
      mdr_q     <= '0;
      mem_out_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_err_q <= req_err_d;
      if (ldMAR) mar_q <= ADDR_W'(Bus);
      if (ldMDR && selMDR == 2'b00) mdr_q <= Bus;
      else if (ldMDR && selMDR == 2'b01) mdr_q <= mem_out_q;
      if (start) begin
        addr_q  <= mar_q[DEPTH_LOG2-1:0];
        wdata_q <= mdr_q;
        op_we_q <= memWE;
      end
      if (commit && !op_we_q) mem_out_q <= rd_data;
    end
  end

  assign busy    = state_q != S_IDLE;
  assign ready   = state_q == S_DONE;
  assign req_err = req_err_q;
  assign MAROut  = mar_q;
  assign MDROut  = mdr_q;
  assign memOut  = mem_out_q;

endmodule
